step_ctrl: RTL and testbench

- Front-end control stage that feeds the LED rotator.
- Conditions two raw push-buttons (direction toggle, pause toggle) and generates a periodic one-cycle `step` enable.
- The LED rotator consumes `dir` directly and advances only on cycles where `step`=1, so the whole design stays on one clock.

---
 rtl/step_ctrl_pkg.sv | 19 +
 rtl/btn_debounce.sv | 86 ++++++++
 rtl/step_ctrl.sv | 75 +++++++
 tb/tb_step_ctrl.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/step_ctrl_pkg.sv
// Shared types and defaults for the step control front end.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package step_ctrl_pkg;

  // Debouncer states: two stable levels, each with an arming state toward the other.
  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    ARM_HI = 2'b01,
    HELD   = 2'b10,
    ARM_LO = 2'b11
  } deb_state_t;

  // One step per second and a 20 ms debounce window at 50 MHz.
  localparam int DEF_DIV         = 50_000_000;
  localparam int DEF_DEB_CYCLES  = 1_000_000;
  localparam int DEF_SYNC_STAGES = 2;

endpackage

// File: rtl/btn_debounce.sv
// Synchronizes one raw button and emits a single-cycle press on a qualified rising level.
// Latency: press is high in the cycle after SYNC_STAGES + DEB_CYCLES cycles of stable high input.
// Backpressure: none; press is a fire-and-forget pulse.
module btn_debounce
  import step_ctrl_pkg::*;
#(
  parameter int DEB_CYCLES  = DEF_DEB_CYCLES,
  parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_raw,
  output logic press
);

  localparam int CW = $clog2(DEB_CYCLES + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEB_CYCLES);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   synced;
  deb_state_t             state, state_nxt;
  logic [CW-1:0]          cnt, cnt_nxt;

  assign synced = sync_q[SYNC_STAGES-1];

  // Metastability chain: shift the raw button in at the bottom.
  always_ff @(posedge clk) begin
    if (!rst_n) sync_q <= '0;
    else        sync_q <= {sync_q[SYNC_STAGES-2:0], btn_raw};
  end

  // Debounce state and qualification counter.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Next state; press fires only on the ARM_HI -> HELD transition, so release is silent.
  // The counter stops at CNT_MAX because it only increments while below it.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    press     = 1'b0;
    case (state)
      IDLE: begin
        if (synced) begin
          state_nxt = ARM_HI;
          cnt_nxt   = CNT_ONE;
        end
      end
      ARM_HI: begin
        if (!synced) begin
          state_nxt = IDLE;
        end else if (cnt == CNT_MAX) begin
          state_nxt = HELD;
          press     = 1'b1;
        end else begin
          cnt_nxt = cnt + CNT_ONE;
        end
      end
      HELD: begin
        if (!synced) begin
          state_nxt = ARM_LO;
          cnt_nxt   = CNT_ONE;
        end
      end
      ARM_LO: begin
        if (synced) begin
          state_nxt = HELD;
        end else if (cnt == CNT_MAX) begin
          state_nxt = IDLE;
        end else begin
          cnt_nxt = cnt + CNT_ONE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: rtl/step_ctrl.sv
// Button-driven direction/pause toggles plus a periodic one-cycle step enable for the LED rotator.
// Latency: step registered, period DIV; dir/paused toggle on the edge the debounced press is seen.
// Backpressure: none; the rotator must consume step on the cycle it is high.
module step_ctrl
  import step_ctrl_pkg::*;
#(
  parameter int DIV         = DEF_DIV,
  parameter int DEB_CYCLES  = DEF_DEB_CYCLES,
  parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_dir,
  input  logic btn_pause,
  output logic step,
  output logic dir,
  output logic paused
);

  localparam int PW = $clog2(DIV);
  localparam logic [PW-1:0] PRE_MAX = PW'(DIV - 1);
  localparam logic [PW-1:0] PRE_ONE = PW'(1);

  logic          press_dir;
  logic          press_pause;
  logic [PW-1:0] pre_cnt;

  btn_debounce #(
    .DEB_CYCLES  (DEB_CYCLES),
    .SYNC_STAGES (SYNC_STAGES)
  ) u_deb_dir (
    .clk     (clk),
    .rst_n   (rst_n),
    .btn_raw (btn_dir),
    .press   (press_dir)
  );

  btn_debounce #(
    .DEB_CYCLES  (DEB_CYCLES),
    .SYNC_STAGES (SYNC_STAGES)
  ) u_deb_pause (
    .clk     (clk),
    .rst_n   (rst_n),
    .btn_raw (btn_pause),
    .press   (press_pause)
  );

  // Prescaler: wraps every DIV cycles and registers step; frozen (count held) while paused.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pre_cnt <= '0;
      step    <= 1'b0;
    end else if (paused) begin
      step <= 1'b0;
    end else if (pre_cnt == PRE_MAX) begin
      pre_cnt <= '0;
      step    <= 1'b1;
    end else begin
      pre_cnt <= pre_cnt + PRE_ONE;
      step    <= 1'b0;
    end
  end

  // Toggle registers; both can flip on the same edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      dir    <= 1'b1;
      paused <= 1'b0;
    end else begin
      if (press_dir)   dir    <= ~dir;
      if (press_pause) paused <= ~paused;
    end
  end

endmodule

// File: tb/tb_step_ctrl.sv
// Directed bench for step_ctrl with DIV=4, DEB_CYCLES=3, SYNC_STAGES=2.
// Edge numbering: R1 is the first posedge with rst_n=1; E1 is the first posedge sampling a button high.
// A clean press toggles its output on E6; step is high after R4, R8, ... while running.
module tb_step_ctrl;
  import step_ctrl_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  logic btn_dir;
  logic btn_pause;
  logic step;
  logic dir;
  logic paused;

  int n_chk  = 0;
  int n_fail = 0;

  step_ctrl #(
    .DIV         (4),
    .DEB_CYCLES  (3),
    .SYNC_STAGES (2)
  ) u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .btn_dir   (btn_dir),
    .btn_pause (btn_pause),
    .step      (step),
    .dir       (dir),
    .paused    (paused)
  );

  always #5 clk = ~clk;

  // Advance one edge and settle before sampling or driving.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Holds reset for n edges with buttons low; the next edge after return is R1.
  task automatic reset_dut(input int n);
    rst_n     = 1'b0;
    btn_dir   = 1'b0;
    btn_pause = 1'b0;
    repeat (n) tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    int pulses;
    logic e;
    rst_n = 1'b0; btn_dir = 1'b0; btn_pause = 1'b0;
    repeat (3) tick();
    n_chk++; if (step !== 1'b0)   begin n_fail++; $display("FAIL rst_step: got %b want 0", step); end
    n_chk++; if (dir !== 1'b1)    begin n_fail++; $display("FAIL rst_dir: got %b want 1", dir); end
    n_chk++; if (paused !== 1'b0) begin n_fail++; $display("FAIL rst_paused: got %b want 0", paused); end
    rst_n  = 1'b1;
    pulses = 0;
    for (int k = 1; k <= 20; k++) begin
      tick();
      e = (k % 4 == 0);
      n_chk++; if (step !== e) begin n_fail++; $display("FAIL run_step R%0d: got %b want %b", k, step, e); end
      if (step === 1'b1) pulses++;
    end
    n_chk++; if (pulses != 5) begin n_fail++; $display("FAIL run_pulses: got %0d want 5", pulses); end
  endtask

  task automatic test_clean_press();
    logic e;
    reset_dut(2);
    tick(); tick();
    btn_dir = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      tick();
      e = (k >= 6) ? 1'b0 : 1'b1;
      n_chk++; if (dir !== e) begin n_fail++; $display("FAIL press_dir E%0d: got %b want %b", k, dir, e); end
    end
    btn_dir = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      tick();
      n_chk++; if (dir !== 1'b0) begin n_fail++; $display("FAIL release_dir L%0d: got %b want 0", k, dir); end
    end
  endtask

  task automatic test_bounce();
    logic [0:8] pat;
    logic e;
    reset_dut(2);
    tick(); tick();
    pat = 9'b101101001;
    for (int i = 0; i < 8; i++) begin
      btn_pause = pat[i];
      tick();
      n_chk++; if (paused !== 1'b0) begin n_fail++; $display("FAIL bounce_hi i%0d: got %b want 0", i, paused); end
    end
    // pat[8] starts the final steady-high run.
    for (int j = 1; j <= 10; j++) begin
      btn_pause = 1'b1;
      tick();
      e = (j >= 6);
      n_chk++; if (paused !== e) begin n_fail++; $display("FAIL steady_hi E%0d: got %b want %b", j, paused, e); end
    end
    pat = 9'b010010110;
    for (int i = 0; i < 9; i++) begin
      btn_pause = pat[i];
      tick();
      n_chk++; if (paused !== 1'b1) begin n_fail++; $display("FAIL bounce_lo i%0d: got %b want 1", i, paused); end
    end
    btn_pause = 1'b0;
    for (int j = 1; j <= 12; j++) begin
      tick();
      n_chk++; if (paused !== 1'b1) begin n_fail++; $display("FAIL steady_lo L%0d: got %b want 1", j, paused); end
    end
  endtask

  task automatic test_pause_resume();
    reset_dut(2);
    tick(); tick(); tick();
    // E1 = R4, so paused rises on R9 when the count has just moved 0 -> 1.
    btn_pause = 1'b1;
    for (int k = 4; k <= 29; k++) begin
      tick();
      if (k == 8) begin
        n_chk++; if (step !== 1'b1) begin n_fail++; $display("FAIL pre_pause_step: got %b want 1", step); end
      end
      if (k == 9) begin
        n_chk++; if (paused !== 1'b1) begin n_fail++; $display("FAIL pause_set: got %b want 1", paused); end
      end
      if (k >= 9) begin
        n_chk++; if (step !== 1'b0) begin n_fail++; $display("FAIL paused_step R%0d: got %b want 0", k, step); end
        n_chk++; if (u_dut.pre_cnt !== 2'd1) begin n_fail++; $display("FAIL paused_cnt R%0d: got %0d want 1", k, u_dut.pre_cnt); end
      end
      if (k == 12) btn_pause = 1'b0;
    end
    // E1 = R30, so paused falls on R35; count 1 -> 2 -> 3 -> wrap gives step after R38.
    btn_pause = 1'b1;
    for (int k = 30; k <= 38; k++) begin
      tick();
      if (k == 34) begin
        n_chk++; if (paused !== 1'b1) begin n_fail++; $display("FAIL resume_early: got %b want 1", paused); end
      end
      if (k == 35) begin
        n_chk++; if (paused !== 1'b0) begin n_fail++; $display("FAIL resume_clr: got %b want 0", paused); end
      end
      if (k == 36 || k == 37) begin
        n_chk++; if (step !== 1'b0) begin n_fail++; $display("FAIL resume_gap R%0d: got %b want 0", k, step); end
      end
      if (k == 38) begin
        n_chk++; if (step !== 1'b1) begin n_fail++; $display("FAIL resume_step: got %b want 1", step); end
      end
    end
    btn_pause = 1'b0;
  endtask

  task automatic test_simultaneous();
    reset_dut(2);
    tick(); tick(); tick();
    // E1 = R4: dir toggles on R9, the edge at which the R8 step is consumed.
    btn_dir = 1'b1;
    for (int k = 4; k <= 12; k++) begin
      tick();
      if (k == 8) begin
        n_chk++; if (step !== 1'b1) begin n_fail++; $display("FAIL coinc_step: got %b want 1", step); end
        n_chk++; if (dir !== 1'b1)  begin n_fail++; $display("FAIL coinc_old_dir: got %b want 1", dir); end
      end
      if (k == 9) begin
        n_chk++; if (dir !== 1'b0) begin n_fail++; $display("FAIL coinc_new_dir: got %b want 0", dir); end
      end
      if (k == 12) begin
        n_chk++; if (step !== 1'b1) begin n_fail++; $display("FAIL next_step: got %b want 1", step); end
        n_chk++; if (dir !== 1'b0)  begin n_fail++; $display("FAIL next_dir: got %b want 0", dir); end
      end
    end
    reset_dut(2);
    tick();
    btn_dir   = 1'b1;
    btn_pause = 1'b1;
    for (int j = 1; j <= 6; j++) begin
      tick();
      if (j == 5) begin
        n_chk++; if (dir !== 1'b1 || paused !== 1'b0) begin n_fail++; $display("FAIL both_early: got dir=%b paused=%b want 1 0", dir, paused); end
      end
      if (j == 6) begin
        n_chk++; if (dir !== 1'b0 || paused !== 1'b1) begin n_fail++; $display("FAIL both_toggle: got dir=%b paused=%b want 0 1", dir, paused); end
      end
    end
    btn_dir   = 1'b0;
    btn_pause = 1'b0;
  endtask

  task automatic test_reset_mid();
    logic e;
    reset_dut(2);
    tick(); tick();
    // E1 = R3: ARM_HI with count 2 after R6, and the prescaler is at 2 after R6.
    btn_dir = 1'b1;
    repeat (4) tick();
    n_chk++; if (u_dut.u_deb_dir.state !== ARM_HI) begin n_fail++; $display("FAIL mid_state: got %0d want %0d", u_dut.u_deb_dir.state, ARM_HI); end
    n_chk++; if (u_dut.u_deb_dir.cnt !== 2'd2) begin n_fail++; $display("FAIL mid_deb_cnt: got %0d want 2", u_dut.u_deb_dir.cnt); end
    n_chk++; if (u_dut.pre_cnt !== 2'd2) begin n_fail++; $display("FAIL mid_pre_cnt: got %0d want 2", u_dut.pre_cnt); end
    rst_n = 1'b0;
    tick();
    n_chk++; if (step !== 1'b0 || dir !== 1'b1 || paused !== 1'b0) begin n_fail++; $display("FAIL mid_rst_out: got %b%b%b want 010", step, dir, paused); end
    n_chk++; if (u_dut.u_deb_dir.state !== IDLE || u_dut.u_deb_dir.cnt !== 2'd0) begin n_fail++; $display("FAIL mid_rst_deb: got state=%0d cnt=%0d want 0 0", u_dut.u_deb_dir.state, u_dut.u_deb_dir.cnt); end
    n_chk++; if (u_dut.pre_cnt !== 2'd0) begin n_fail++; $display("FAIL mid_rst_pre: got %0d want 0", u_dut.pre_cnt); end
    tick();
    rst_n = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      tick();
      e = (k >= 6) ? 1'b0 : 1'b1;
      n_chk++; if (dir !== e) begin n_fail++; $display("FAIL requal_dir R%0d: got %b want %b", k, dir, e); end
    end
    btn_dir = 1'b0;
  endtask

  initial begin
    rst_n     = 1'b0;
    btn_dir   = 1'b0;
    btn_pause = 1'b0;
    test_reset();
    test_clean_press();
    test_bounce();
    test_pause_resume();
    test_simultaneous();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, failures so far %0d", n_fail);
    $fatal(1);
  end

endmodule
